uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
Transmit-side controller for the UART peripheral. It sequences the 8-entry TX FIFO: pops one byte at a time and serialises it onto the line as a start bit, 8 data bits LSB first, an optional parity bit and 1 or 2 stop bits. It contains a programmable baud-tick generator. It sits between the register-mapped TX FIFO and the tx pad, and reports busy, per-byte completion and a sent-byte count to the interrupt/status logic.

Parameters:
DIV_W, 16, width of the baud divider (clock cycles per bit)
CNT_W, 8, width of the transmitted-byte counter

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset; synchronous, active-high
tx_en_i  in  1  transmit enable; gates the start of new frames only
baud_div_i  in  DIV_W  clock cycles per bit; 0 is treated as 1
parity_en_i  in  1  1 = append a parity bit
parity_odd_i  in  1  1 = odd parity, 0 = even parity
stop2_i  in  1  1 = two stop bits, 0 = one stop bit
fifo_empty_i  in  1  TX FIFO empty flag
fifo_rd_en_o  out  1  FIFO pop strobe; exactly one cycle per byte
fifo_data_i  in  8  FIFO read data; valid in the cycle after fifo_rd_en_o
tx_o  out  1  serial line; idles high
busy_o  out  1  high in every state other than IDLE
byte_done_o  out  1  one-cycle pulse in the last cycle of the final stop bit
tx_count_o  out  CNT_W  count of completed frames, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst_i sampled high at a clk_i edge) forces:
  - state=IDLE, tx_o=1, fifo_rd_en_o=0, busy_o=0, byte_done_o=0, tx_count_o=0;
  - baud counter, bit index and shift register cleared.
  - Reset mid-frame aborts the frame immediately; the line returns high on the next cycle. A byte already popped is lost.
- States and transitions:
  - IDLE: tx_o=1. If tx_en_i=1 and fifo_empty_i=0, go to FETCH. Otherwise stay.
  - FETCH: one cycle. fifo_rd_en_o=1 (registered, so high only in this cycle). Go to LOAD.
  - LOAD: one cycle; tx_o=1.
    - Capture fifo_data_i into the shift register.
    - Latch baud_div_i, parity_en_i, parity_odd_i and stop2_i. Config changes mid-frame have no effect on the current frame.
    - Compute parity = ^data XOR parity_odd.
    - Go to START.
  - START: tx_o=0 for N cycles, where N = latched divider (minimum 1). Go to DATA.
  - DATA: tx_o = shift register bit 0 for N cycles per bit, then shift right. After 8 bits, go to PARITY if parity is enabled, else STOP.
  - PARITY: tx_o = latched parity bit for N cycles. Go to STOP.
  - STOP: tx_o=1 for N cycles (2N if stop2).
    - In the last STOP cycle: byte_done_o=1 and tx_count_o increments.
    - Next state is FETCH if tx_en_i=1 and fifo_empty_i=0 in that cycle; otherwise IDLE.
- Baud counter:
  - Loads N-1 on entry to each bit and decrements to 0.
  - The bit ends in the cycle where the counter is 0.
  - No tick is generated in IDLE, FETCH or LOAD.
- Timing and ordering:
  - tx_o is driven from a register; its change follows the state change by 0 cycles (Moore output).
  - Back-to-back frames: the stop bit is followed by exactly 2 high cycles (FETCH, LOAD) before the next start bit.
  - tx_en_i deasserted mid-frame: the current frame completes fully, then the block returns to IDLE. No pop occurs.
  - fifo_rd_en_o is never asserted when fifo_empty_i was 1 in the deciding cycle, so the FIFO is never underflowed.
  - fifo_empty_i rising during a frame has no effect until the STOP decision.
- Frame length from START entry: N × (10 + parity_en + stop2) cycles.
- tx_count_o wraps from 2^CNT_W−1 to 0 with no flag.

Test Plan:
- Basic frame. Reset, then baud_div=4, no parity, 1 stop, FIFO holds 0xA5, tx_en=1.
  - Required: fifo_rd_en_o high for 1 cycle.
  - tx_o, 4 cycles per bit: 0 | 1,0,1,0,0,1,0,1 | 1.
  - byte_done_o pulses in cycle 40 after START entry; tx_count_o=1; busy_o drops the next cycle.
- Parity. Send 0xA5 (four ones) with parity_en=1.
  - parity_odd=0 → parity bit 0; parity_odd=1 → parity bit 1.
  - Frame is 44 cycles at baud_div=4.
- Back-to-back and 2 stop bits. FIFO holds 0x00, 0xFF; stop2=1, baud_div=2.
  - Stop bit is 4 cycles high, then exactly 2 high cycles, then the second start bit.
  - Two rd_en pulses in total; tx_count_o=2.
- Enable drop. Deassert tx_en_i midway through DATA with 3 bytes queued.
  - The frame finishes intact; no further rd_en; block returns to IDLE with tx_count_o=1.
- Divider edge and config latch.
  - baud_div=0 → 1 cycle per bit; a 10-cycle frame is sent.
  - Change baud_div 4→8 mid-frame → the current frame keeps 4-cycle bits and the next frame uses 8.
- Reset mid-frame and wrap.
  - rst_i asserted during PARITY → the next cycle shows tx_o=1, busy_o=0, tx_count_o=0.
  - Separately, 256 frames with CNT_W=8 → tx_count_o wraps to 0.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
//   Transmit-side UART controller. Pops bytes from the TX FIFO one at a time
//   and serialises each as: start bit, 8 data bits LSB first, optional parity
//   bit, then 1 or 2 stop bits. Bit time is a programmable number of clocks.
//
// Ports
//   clk_i         system clock
//   rst_i         synchronous active-high reset
//   tx_en_i       transmit enable (only gates the start of new frames)
//   baud_div_i    clock cycles per bit, 0 treated as 1
//   parity_en_i   append parity bit
//   parity_odd_i  1 = odd parity, 0 = even parity
//   stop2_i       1 = two stop bits
//   fifo_empty_i  TX FIFO empty flag
//   fifo_rd_en_o  one-cycle FIFO pop strobe per byte
//   fifo_data_i   FIFO read data, valid the cycle after fifo_rd_en_o
//   tx_o          serial line, idles high
//   busy_o        high whenever not idle
//   byte_done_o   pulse in the last cycle of the final stop bit
//   tx_count_o    completed-frame counter, wraps
// ---------------------------------------------------------------------------
module uart_tx_ctrl #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tx_en_i,
    input  logic [DIV_W-1:0] baud_div_i,
    input  logic             parity_en_i,
    input  logic             parity_odd_i,
    input  logic             stop2_i,
    input  logic             fifo_empty_i,
    output logic             fifo_rd_en_o,
    input  logic [7:0]       fifo_data_i,
    output logic             tx_o,
    output logic             busy_o,
    output logic             byte_done_o,
    output logic [CNT_W-1:0] tx_count_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               par_en_q, par_en_d;
    logic               par_q, par_d;
    logic               stop2_q, stop2_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               tx_q, tx_d;
    logic               rd_q, rd_d;
    logic               busy_q, busy_d;
    logic               done;

    // Counter reload value for the latched divider (N-1, with N=0 acting as 1)
    logic [DIV_W-1:0]   reload;
    logic               bit_end;

    assign reload  = (div_q == '0) ? '0 : div_q - DIV_W'(1);
    assign bit_end = (cnt_q == '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        div_d    = div_q;
        par_en_d = par_en_q;
        par_d    = par_q;
        stop2_d  = stop2_q;
        count_d  = count_q;
        done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tx_en_i && !fifo_empty_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                // Frame config is frozen here so mid-frame changes are ignored
                shift_d  = fifo_data_i;
                div_d    = baud_div_i;
                par_en_d = parity_en_i;
                par_d    = (^fifo_data_i) ^ parity_odd_i;
                stop2_d  = stop2_i;
                cnt_d    = (baud_div_i == '0) ? '0 : baud_div_i - DIV_W'(1);
                bit_d    = '0;
                state_d  = S_START;
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = reload;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d   = reload;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    cnt_d   = reload;
                    bit_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    // bit_q tracks which stop bit we are in when two are used
                    if (stop2_q && (bit_q == 3'd0)) begin
                        bit_d = 3'd1;
                        cnt_d = reload;
                    end else begin
                        done    = 1'b1;
                        count_d = count_q + CNT_W'(1);
                        bit_d   = '0;
                        state_d = (tx_en_i && !fifo_empty_i) ? S_FETCH : S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered outputs decoded from the next state so they change together
    // with the state register.
    always_comb begin
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
        rd_d   = (state_d == S_FETCH);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            div_q    <= '0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            stop2_q  <= 1'b0;
            count_q  <= '0;
            tx_q     <= 1'b1;
            rd_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            div_q    <= div_d;
            par_en_q <= par_en_d;
            par_q    <= par_d;
            stop2_q  <= stop2_d;
            count_q  <= count_d;
            tx_q     <= tx_d;
            rd_q     <= rd_d;
            busy_q   <= busy_d;
        end
    end

    assign tx_o         = tx_q;
    assign fifo_rd_en_o = rd_q;
    assign busy_o       = busy_q;
    assign byte_done_o  = done;
    assign tx_count_o   = count_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_en;
    logic [15:0] baud_div;
    logic        parity_en;
    logic        parity_odd;
    logic        stop2;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  fifo_data = 8'h00;
    logic        tx;
    logic        busy;
    logic        byte_done;
    logic [7:0]  tx_count;

    int n_cmp = 0;
    int n_err = 0;
    int exp_count = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(.DIV_W(16), .CNT_W(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .tx_en_i      (tx_en),
        .baud_div_i   (baud_div),
        .parity_en_i  (parity_en),
        .parity_odd_i (parity_odd),
        .stop2_i      (stop2),
        .fifo_empty_i (fifo_empty),
        .fifo_rd_en_o (fifo_rd_en),
        .fifo_data_i  (fifo_data),
        .tx_o         (tx),
        .busy_o       (busy),
        .byte_done_o  (byte_done),
        .tx_count_o   (tx_count)
    );

    // Behavioural FIFO: data appears the cycle after a pop strobe
    logic [7:0] mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int rd_cnt = 0;
    int underflow = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            rd_cnt <= rd_cnt + 1;
            if (wr_ptr == rd_ptr) underflow <= underflow + 1;
            else begin
                fifo_data <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 1;
            end
        end
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr++;
    endtask

    task automatic set_cfg(input int div, input bit pe, input bit po, input bit s2);
        baud_div   = 16'(div);
        parity_en  = pe;
        parity_odd = po;
        stop2      = s2;
    endtask

    // Waits for a start bit, then checks every cycle of the frame against the
    // frame built from the byte and the config the DUT should have latched.
    task automatic check_frame(input logic [7:0] d, input int n, input bit pe, input bit po,
                               input bit s2, input bit gap, input int chg_at, input int new_div,
                               input int drop_at, input string nm);
        int hi, len, err, derr, first, b;
        logic eb, par;
        hi = 0;
        @(negedge clk);
        while (tx !== 1'b0 && hi < 200) begin
            hi++;
            @(negedge clk);
        end
        n_cmp++;
        if (tx !== 1'b0) begin
            n_err++;
            $display("FAIL %s start: no start bit within %0d cycles (tx=%b)", nm, hi, tx);
            return;
        end
        if (gap) begin
            n_cmp++;
            if (hi !== 2) begin
                n_err++;
                $display("FAIL %s gap: %0d idle-high cycles, expected 2", nm, hi);
            end
        end
        par   = ($countones(d) % 2 == 1) ^ po;
        len   = n * (10 + int'(pe) + int'(s2));
        err   = 0;
        derr  = 0;
        first = -1;
        for (int c = 1; c <= len; c++) begin
            b = (c - 1) / n;
            if (b == 0) eb = 1'b0;
            else if (b <= 8) eb = d[b-1];
            else if (b == 9 && pe) eb = par;
            else eb = 1'b1;
            if (tx !== eb || busy !== 1'b1) begin
                err++;
                if (first < 0) first = c;
            end
            if (byte_done !== (c == len)) derr++;
            if (c == chg_at) baud_div = 16'(new_div);
            if (c == drop_at) tx_en = 1'b0;
            if (c < len) @(negedge clk);
        end
        n_cmp++;
        if (err != 0) begin
            n_err++;
            $display("FAIL %s wave: %0d bad cycles, first at %0d, byte %02h, expected 0", nm, err, first, d);
        end
        n_cmp++;
        if (derr != 0) begin
            n_err++;
            $display("FAIL %s byte_done: %0d bad cycles, expected pulse only at cycle %0d", nm, derr, len);
        end
        exp_count++;
    endtask

    task automatic check_idle(input string nm, input int rd_exp, input int rd0);
        n_cmp++;
        if (busy !== 1'b0 || tx !== 1'b1 || tx_count !== 8'(exp_count) || (rd_cnt - rd0) !== rd_exp) begin
            n_err++;
            $display("FAIL %s idle: busy=%b tx=%b count=%0d pops=%0d, expected 0/1/%0d/%0d",
                     nm, busy, tx, tx_count, rd_cnt - rd0, 8'(exp_count), rd_exp);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; tx_en = 1'b0;
        set_cfg(4, 0, 0, 0);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0 || byte_done !== 1'b0 || tx_count !== 8'd0) begin
            n_err++;
            $display("FAIL reset: tx=%b busy=%b rd=%b done=%b count=%0d, expected 1/0/0/0/0",
                     tx, busy, fifo_rd_en, byte_done, tx_count);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int rd0 = rd_cnt;
        set_cfg(4, 0, 0, 0);
        push(8'hA5);
        tx_en = 1'b1;
        check_frame(8'hA5, 4, 0, 0, 0, 0, 0, 0, 0, "basic");
        @(negedge clk);
        check_idle("basic", 1, rd0);
    endtask

    task automatic test_parity;
        for (int po = 0; po < 2; po++) begin
            int rd0 = rd_cnt;
            set_cfg(4, 1, po[0], 0);
            push(8'hA5);
            check_frame(8'hA5, 4, 1, po[0], 0, 0, 0, 0, 0, po ? "parity_odd" : "parity_even");
            @(negedge clk);
            check_idle("parity", 1, rd0);
        end
    endtask

    task automatic test_back_to_back;
        int rd0 = rd_cnt;
        set_cfg(2, 0, 0, 1);
        push(8'h00); push(8'hFF);
        check_frame(8'h00, 2, 0, 0, 1, 0, 0, 0, 0, "b2b_0");
        check_frame(8'hFF, 2, 0, 0, 1, 1, 0, 0, 0, "b2b_1");
        @(negedge clk);
        check_idle("b2b", 2, rd0);
    endtask

    task automatic test_enable_drop;
        int rd0 = rd_cnt;
        set_cfg(4, 0, 0, 0);
        push(8'h3C); push(8'h81); push(8'h5A);
        tx_en = 1'b1;
        check_frame(8'h3C, 4, 0, 0, 0, 0, 0, 0, 20, "en_drop");
        repeat (30) @(negedge clk);
        check_idle("en_drop", 1, rd0);
        rd0 = rd_cnt;
        tx_en = 1'b1;
        check_frame(8'h81, 4, 0, 0, 0, 0, 0, 0, 0, "en_resume0");
        check_frame(8'h5A, 4, 0, 0, 0, 1, 0, 0, 0, "en_resume1");
        @(negedge clk);
        check_idle("en_resume", 2, rd0);
    endtask

    task automatic test_divider;
        int rd0 = rd_cnt;
        set_cfg(0, 0, 0, 0);
        push(8'h96);
        check_frame(8'h96, 1, 0, 0, 0, 0, 0, 0, 0, "div0");
        @(negedge clk);
        check_idle("div0", 1, rd0);
        rd0 = rd_cnt;
        set_cfg(4, 0, 0, 0);
        push(8'h6B); push(8'hD2);
        check_frame(8'h6B, 4, 0, 0, 0, 0, 10, 8, 0, "latch_old");
        check_frame(8'hD2, 8, 0, 0, 0, 1, 0, 0, 0, "latch_new");
        @(negedge clk);
        check_idle("latch", 2, rd0);
    endtask

    task automatic test_random;
        for (int s = 0; s < 3; s++) begin
            int rd0 = rd_cnt;
            int div = int'($urandom_range(0, 5));
            bit pe = 1'($urandom_range(0, 1));
            bit po = 1'($urandom_range(0, 1));
            bit s2 = 1'($urandom_range(0, 1));
            logic [7:0] bytes [0:3];
            set_cfg(div, pe, po, s2);
            for (int i = 0; i < 4; i++) begin
                bytes[i] = 8'($urandom);
                push(bytes[i]);
            end
            for (int i = 0; i < 4; i++)
                check_frame(bytes[i], (div == 0) ? 1 : div, pe, po, s2, i != 0, 0, 0, 0, "random");
            @(negedge clk);
            check_idle("random", 4, rd0);
        end
    endtask

    task automatic test_reset_mid;
        int hi = 0;
        set_cfg(3, 1, 0, 0);
        push(8'h3C);  // four ones, even parity bit = 0
        @(negedge clk);
        while (tx !== 1'b0 && hi < 50) begin
            hi++;
            @(negedge clk);
        end
        repeat (27) @(negedge clk);
        n_cmp++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid pre: tx=%b busy=%b in parity bit, expected 0/1", tx, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (tx !== 1'b1 || busy !== 1'b0 || tx_count !== 8'd0 || byte_done !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid: tx=%b busy=%b count=%0d done=%b, expected 1/0/0/0",
                     tx, busy, tx_count, byte_done);
        end
        rst = 1'b0;
        exp_count = 0;
        repeat (5) @(negedge clk);
        check_idle("rst_mid_after", 0, rd_cnt);
    endtask

    task automatic test_wrap;
        int rd0 = rd_cnt;
        logic [7:0] b;
        set_cfg(1, 0, 0, 0);
        for (int i = 0; i < 256; i++) push(8'(i * 37 + 11));
        for (int i = 0; i < 256; i++) begin
            b = 8'(i * 37 + 11);
            check_frame(b, 1, 0, 0, 0, i != 0, 0, 0, 0, "wrap");
        end
        @(negedge clk);
        check_idle("wrap", 256, rd0);
        n_cmp++;
        if (tx_count !== 8'd0) begin
            n_err++;
            $display("FAIL wrap count: %0d, expected 0", tx_count);
        end
    endtask

    initial begin
        rst = 1'b1;
        tx_en = 1'b0;
        set_cfg(4, 0, 0, 0);
        test_reset;
        test_basic;
        test_parity;
        test_back_to_back;
        test_enable_drop;
        test_divider;
        test_random;
        test_reset_mid;
        test_wrap;
        n_cmp++;
        if (underflow !== 0) begin
            n_err++;
            $display("FAIL underflow: %0d pops from empty FIFO, expected 0", underflow);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
